// File: rtl/stmm_pkg.sv
// Shared types and sizing for the StMM command dispatcher.
// Vector width, issue/writeback FSM encodings, command record and a one-hot helper.
package stmm_pkg;
  localparam int SUB_NUM = 4;
  localparam int N       = 176;
  localparam int Q       = 8;
  localparam int VW      = N * Q;
  localparam int VREG_AW = 6;
  localparam int SW      = $clog2(SUB_NUM);

  typedef logic [VW-1:0]      vec_t;
  typedef logic [SW-1:0]      sub_t;
  typedef logic [VREG_AW-1:0] vaddr_t;
  typedef logic [SUB_NUM-1:0] sub_mask_t;

  typedef enum logic [1:0] {ISS_IDLE, ISS_RD, ISS_LOAD, ISS_EXEC} iss_state_e;
  typedef enum logic {WB_IDLE, WB_CAP} wb_state_e;

  typedef struct packed {
    sub_t   sub;
    vaddr_t src;
    vaddr_t dst;
  } stmm_cmd_t;

  function automatic sub_mask_t sub_onehot(input sub_t s);
    sub_mask_t m;
    m    = '0;
    m[s] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/stmm_dispatch_if.sv
// Command channel into the dispatcher: valid/ready handshake plus sub-unit, source and destination.
// Ready is combinational on the dispatcher side and may depend on cmd_sub.
interface stmm_dispatch_if;
  import stmm_pkg::*;

  logic   cmd_valid;
  logic   cmd_ready;
  sub_t   cmd_sub;
  vaddr_t cmd_src;
  vaddr_t cmd_dst;

  modport master (output cmd_valid, output cmd_sub, output cmd_src, output cmd_dst,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_sub, input  cmd_src, input  cmd_dst,
                  output cmd_ready);
endinterface

// File: rtl/priority_encoder.sv
// Lowest-index-wins priority encoder, purely combinational.
// idx is 0 when nothing is requested; qualify with any.
module priority_encoder #(
  parameter int W  = 4,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

  assign any = |req;
endmodule

// File: rtl/stmm_wb_sel.sv
// Picks the next sub-unit to retire: lowest index among pending results.
// Combinational, no state; retirement order is therefore strictly by index.
module stmm_wb_sel
  import stmm_pkg::*;
(
  input  sub_mask_t pend,
  output sub_t      idx,
  output logic      any
);
  priority_encoder #(
    .W  (SUB_NUM),
    .IW (SW)
  ) u_pe (
    .req (pend),
    .idx (idx),
    .any (any)
  );
endmodule

// File: rtl/stmm_dispatch.sv
// Sequences vreg read -> StMM load -> exec, then retires results back to vregs in index order.
// Issue takes 4 cycles per command; retire takes 2 cycles per result; busy sub-units hold off cmd_ready.
module stmm_dispatch
  import stmm_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  stmm_dispatch_if.slave cmd,
  output logic           vreg_re,
  output vaddr_t         vreg_raddr,
  input  vec_t           vreg_rdata,
  output logic           vreg_we,
  output vaddr_t         vreg_waddr,
  output vec_t           vreg_wdata,
  output sub_mask_t      input_we,
  output vec_t           input_data,
  output sub_mask_t      exec,
  input  sub_mask_t      exec_done,
  output sub_mask_t      output_re,
  input  vec_t           output_data,
  output sub_mask_t      sub_busy,
  output logic           wb_done,
  output sub_t           wb_sub,
  output logic           err_spur,
  output logic           idle
);
  iss_state_e iss_state;
  sub_t       cur_sub;
  vaddr_t     cur_src;
  vaddr_t     dst_tbl [SUB_NUM];

  wb_state_e  wb_state;
  sub_t       wb_j;
  sub_mask_t  pend;

  stmm_cmd_t  in_cmd;
  logic       accept;
  sub_t       sel_idx;
  logic       sel_any;
  sub_mask_t  busy_set;
  sub_mask_t  busy_clr;

  assign in_cmd        = '{sub: cmd.cmd_sub, src: cmd.cmd_src, dst: cmd.cmd_dst};
  assign cmd.cmd_ready = (iss_state == ISS_IDLE) && !sub_busy[cmd.cmd_sub];
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (accept)             busy_set = sub_onehot(in_cmd.sub);
    if (wb_state == WB_CAP) busy_clr = sub_onehot(wb_j);
  end

  // Issue sequencer: one command in flight, fixed RD/LOAD/EXEC walk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_state <= ISS_IDLE;
      cur_sub   <= '0;
      cur_src   <= '0;
      for (int i = 0; i < SUB_NUM; i++) dst_tbl[i] <= '0;
    end else begin
      case (iss_state)
        ISS_IDLE: begin
          if (accept) begin
            cur_sub             <= in_cmd.sub;
            cur_src             <= in_cmd.src;
            dst_tbl[in_cmd.sub] <= in_cmd.dst;
            iss_state           <= ISS_RD;
          end
        end
        ISS_RD:   iss_state <= ISS_LOAD;
        ISS_LOAD: iss_state <= ISS_EXEC;
        ISS_EXEC: iss_state <= ISS_IDLE;
        default:  iss_state <= ISS_IDLE;
      endcase
    end
  end

  stmm_wb_sel u_wb_sel (
    .pend (pend),
    .idx  (sel_idx),
    .any  (sel_any)
  );

  // Writeback: output_re in WB_IDLE, data lands one cycle later in WB_CAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_state <= WB_IDLE;
      wb_j     <= '0;
    end else begin
      case (wb_state)
        WB_IDLE: begin
          if (sel_any) begin
            wb_j     <= sel_idx;
            wb_state <= WB_CAP;
          end
        end
        WB_CAP:  wb_state <= WB_IDLE;
        default: wb_state <= WB_IDLE;
      endcase
    end
  end

  // A done pulse counts only for an owned sub-unit; anything else is flagged and dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_busy <= '0;
      pend     <= '0;
      err_spur <= 1'b0;
    end else begin
      sub_busy <= (sub_busy & ~busy_clr) | busy_set;
      pend     <= (pend | (exec_done & sub_busy)) & ~busy_clr;
      if (|(exec_done & ~sub_busy)) err_spur <= 1'b1;
    end
  end

  assign vreg_re    = (iss_state == ISS_RD);
  assign vreg_raddr = cur_src;
  assign input_we   = (iss_state == ISS_LOAD) ? sub_onehot(cur_sub) : '0;
  assign input_data = vreg_rdata;
  assign exec       = (iss_state == ISS_EXEC) ? sub_onehot(cur_sub) : '0;

  assign output_re  = ((wb_state == WB_IDLE) && sel_any) ? sub_onehot(sel_idx) : '0;
  assign vreg_we    = (wb_state == WB_CAP);
  assign vreg_waddr = dst_tbl[wb_j];
  assign vreg_wdata = output_data;
  assign wb_done    = vreg_we;
  assign wb_sub     = wb_j;

  assign idle       = (sub_busy == '0) && (iss_state == ISS_IDLE);
endmodule

// File: tb/tb_stmm_dispatch.sv
// Directed bench for stmm_dispatch with a vreg RAM model and a StMM stub (Y = ~X).
module tb_stmm_dispatch;
  import stmm_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  always #5 clk = ~clk;

  stmm_dispatch_if cif();

  logic      vreg_re;
  vaddr_t    vreg_raddr;
  vec_t      vreg_rdata;
  logic      vreg_we;
  vaddr_t    vreg_waddr;
  vec_t      vreg_wdata;
  sub_mask_t input_we;
  vec_t      input_data;
  sub_mask_t exec;
  sub_mask_t exec_done;
  sub_mask_t output_re;
  vec_t      output_data;
  sub_mask_t sub_busy;
  logic      wb_done;
  sub_t      wb_sub;
  logic      err_spur;
  logic      idle;

  stmm_dispatch dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cif),
    .vreg_re     (vreg_re),
    .vreg_raddr  (vreg_raddr),
    .vreg_rdata  (vreg_rdata),
    .vreg_we     (vreg_we),
    .vreg_waddr  (vreg_waddr),
    .vreg_wdata  (vreg_wdata),
    .input_we    (input_we),
    .input_data  (input_data),
    .exec        (exec),
    .exec_done   (exec_done),
    .output_re   (output_re),
    .output_data (output_data),
    .sub_busy    (sub_busy),
    .wb_done     (wb_done),
    .wb_sub      (wb_sub),
    .err_spur    (err_spur),
    .idle        (idle)
  );

  function automatic vec_t vpat(input int a);
    vec_t r;
    for (int e = 0; e < N; e++) r[e*Q +: Q] = 8'(a * 7 + e);
    return r;
  endfunction

  // Environment: vreg RAM (read data next cycle) and StMM stub holding ~X per sub-unit.
  vec_t vmem [64];
  vec_t yreg [SUB_NUM];
  int   cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      for (int a = 0; a < 64; a++) vmem[a] <= vpat(a);
    end else begin
      if (vreg_re) vreg_rdata <= vmem[vreg_raddr];
      if (vreg_we) vmem[vreg_waddr] <= vreg_wdata;
    end
    for (int i = 0; i < SUB_NUM; i++) begin
      if (input_we[i])  yreg[i] <= ~input_data;
      if (output_re[i]) output_data <= yreg[i];
    end
  end

  typedef struct {
    sub_t   sub;
    vaddr_t addr;
    vec_t   data;
    int     cyc;
  } ret_t;
  ret_t rq[$];
  always @(negedge clk) begin
    if (wb_done) rq.push_back('{wb_sub, vreg_waddr, vreg_wdata, cyc});
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act[31:0]=%08h exp[31:0]=%08h", nm, act[31:0], exp[31:0]);
    end
  endtask

  task automatic chk_ret(input string nm, input int idx, input sub_t s, input vaddr_t a,
                         input vec_t d);
    if (idx < rq.size()) begin
      chk({nm, "_sub"}, 32'(rq[idx].sub), 32'(s));
      chk({nm, "_addr"}, 32'(rq[idx].addr), 32'(a));
      chkv({nm, "_data"}, rq[idx].data, d);
    end else begin
      checks++;
      errors++;
      $display("FAIL %s missing retire idx=%0d have=%0d", nm, idx, rq.size());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Hold a command valid until ready; returns at the mid-point of the accept cycle (C0).
  task automatic send(input sub_t s, input vaddr_t sr, input vaddr_t ds);
    int n;
    tick();
    cif.cmd_valid = 1'b1;
    cif.cmd_sub   = s;
    cif.cmd_src   = sr;
    cif.cmd_dst   = ds;
    mid();
    n = 0;
    while (!cif.cmd_ready && n < 100) begin
      tick();
      mid();
      n++;
    end
    chk("send_ready", 32'(cif.cmd_ready), 1);
  endtask

  // Full issue through the exec cycle (C3).
  task automatic issue(input sub_t s, input vaddr_t sr, input vaddr_t ds);
    send(s, sr, ds);
    tick();
    cif.cmd_valid = 1'b0;
    mid();
    tick(); mid();
    tick(); mid();
  endtask

  task automatic wait_ret(input string nm, input int cnt);
    int n;
    n = 0;
    while (rq.size() < cnt && n < 50) begin
      tick();
      mid();
      n++;
    end
    chk(nm, 32'(rq.size()), 32'(cnt));
  endtask

  typedef struct {
    sub_t      sub;
    vaddr_t    src;
    vaddr_t    dst;
    int        dly;
    sub_mask_t oh;
  } vec_rec_t;
  vec_rec_t tv [4];

  initial begin
    int b;
    int rdy_seen;
    tv[0] = '{2'd2, 6'd5,  6'd9,  20, 4'b0100};
    tv[1] = '{2'd0, 6'd1,  6'd2,  3,  4'b0001};
    tv[2] = '{2'd3, 6'd63, 6'd0,  5,  4'b1000};
    tv[3] = '{2'd1, 6'd10, 6'd63, 7,  4'b0010};

    rst           = 1'b1;
    cif.cmd_valid = 1'b0;
    cif.cmd_sub   = '0;
    cif.cmd_src   = '0;
    cif.cmd_dst   = '0;
    exec_done     = '0;
    repeat (3) @(posedge clk);
    mid();
    chk("rst_vreg_re", 32'(vreg_re), 0);
    chk("rst_input_we", 32'(input_we), 0);
    chk("rst_exec", 32'(exec), 0);
    chk("rst_output_re", 32'(output_re), 0);
    chk("rst_vreg_we", 32'(vreg_we), 0);
    chk("rst_wb_done", 32'(wb_done), 0);
    chk("rst_sub_busy", 32'(sub_busy), 0);
    chk("rst_err_spur", 32'(err_spur), 0);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_cmd_ready", 32'(cif.cmd_ready), 1);
    tick();
    rst = 1'b0;

    // Single commands through the whole pipe, one table row at a time.
    for (int k = 0; k < 4; k++) begin
      send(tv[k].sub, tv[k].src, tv[k].dst);
      chk("c0_idle", 32'(idle), 1);
      tick(); cif.cmd_valid = 1'b0; mid();
      chk("c1_vreg_re", 32'(vreg_re), 1);
      chk("c1_raddr", 32'(vreg_raddr), 32'(tv[k].src));
      chk("c1_busy", 32'(sub_busy), 32'(tv[k].oh));
      chk("c1_input_we", 32'(input_we), 0);
      chk("c1_idle", 32'(idle), 0);
      tick(); mid();
      chk("c2_input_we", 32'(input_we), 32'(tv[k].oh));
      chkv("c2_input_data", input_data, vpat(int'(tv[k].src)));
      chk("c2_exec", 32'(exec), 0);
      tick(); mid();
      chk("c3_exec", 32'(exec), 32'(tv[k].oh));
      chk("c3_input_we", 32'(input_we), 0);
      tick(); mid();
      chk("c4_exec", 32'(exec), 0);
      repeat (tv[k].dly) begin tick(); mid(); end
      tick(); exec_done = tv[k].oh; mid();
      chk("done_output_re", 32'(output_re), 0);
      tick(); exec_done = '0; mid();
      chk("wb_output_re", 32'(output_re), 32'(tv[k].oh));
      chk("wb_vreg_we_early", 32'(vreg_we), 0);
      tick(); mid();
      chk("wb_vreg_we", 32'(vreg_we), 1);
      chk("wb_done", 32'(wb_done), 1);
      chk("wb_sub", 32'(wb_sub), 32'(tv[k].sub));
      chk("wb_waddr", 32'(vreg_waddr), 32'(tv[k].dst));
      chkv("wb_wdata", vreg_wdata, ~vpat(int'(tv[k].src)));
      chk("wb_output_re_off", 32'(output_re), 0);
      tick(); mid();
      chk("post_wb_done", 32'(wb_done), 0);
      chk("post_busy", 32'(sub_busy), 0);
      chk("post_idle", 32'(idle), 1);
      chkv("post_vmem", vmem[tv[k].dst], ~vpat(int'(tv[k].src)));
    end

    // Back-to-back commands with cmd_valid held high.
    b = rq.size();
    tick();
    cif.cmd_valid = 1'b1; cif.cmd_sub = 2'd0; cif.cmd_src = 6'd11; cif.cmd_dst = 6'd12;
    mid();
    chk("b2b_ready_c0", 32'(cif.cmd_ready), 1);
    tick(); cif.cmd_sub = 2'd1; cif.cmd_src = 6'd13; cif.cmd_dst = 6'd14; mid();
    chk("b2b_ready_c1", 32'(cif.cmd_ready), 0);
    tick(); mid();
    chk("b2b_ready_c2", 32'(cif.cmd_ready), 0);
    tick(); mid();
    chk("b2b_ready_c3", 32'(cif.cmd_ready), 0);
    tick(); mid();
    chk("b2b_ready_c4", 32'(cif.cmd_ready), 1);
    tick(); cif.cmd_valid = 1'b0; mid();
    chk("b2b_busy", 32'(sub_busy), 32'h3);
    tick(); mid();
    tick(); mid();
    chk("b2b_exec1", 32'(exec), 32'h2);
    tick(); exec_done = 4'b0001; mid();
    tick(); exec_done = 4'b0010; mid();
    tick(); exec_done = '0; mid();
    wait_ret("b2b_cnt", b + 2);
    chk_ret("b2b_r0", b,     2'd0, 6'd12, ~vpat(11));
    chk_ret("b2b_r1", b + 1, 2'd1, 6'd14, ~vpat(13));

    // All four sub-units finish in the same cycle.
    for (int i = 0; i < 4; i++) issue(sub_t'(i), vaddr_t'(30 + i), vaddr_t'(20 + i));
    chk("all_busy", 32'(sub_busy), 32'hF);
    b = rq.size();
    tick(); exec_done = 4'b1111; mid();
    tick(); exec_done = '0; mid();
    wait_ret("multi_cnt", b + 4);
    for (int i = 0; i < 4; i++) begin
      chk_ret("multi", b + i, sub_t'(i), vaddr_t'(20 + i), ~vpat(30 + i));
      if (i > 0 && b + i < rq.size())
        chk("multi_gap", 32'(rq[b+i].cyc - rq[b+i-1].cyc), 2);
    end

    // Command to a busy sub-unit waits until the cycle after its retire.
    b = rq.size();
    issue(2'd1, 6'd40, 6'd41);
    tick();
    cif.cmd_valid = 1'b1; cif.cmd_sub = 2'd1; cif.cmd_src = 6'd42; cif.cmd_dst = 6'd43;
    mid();
    rdy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (cif.cmd_ready) rdy_seen++;
      tick(); mid();
    end
    chk("busy_ready_held", 32'(rdy_seen), 0);
    tick(); exec_done = 4'b0010; mid();
    chk("busy_ready_done", 32'(cif.cmd_ready), 0);
    tick(); exec_done = '0; mid();
    chk("busy_ready_ore", 32'(cif.cmd_ready), 0);
    tick(); mid();
    chk("busy_wb_done", 32'(wb_done), 1);
    chk("busy_ready_wb", 32'(cif.cmd_ready), 0);
    tick(); mid();
    chk("busy_ready_after", 32'(cif.cmd_ready), 1);
    tick(); cif.cmd_valid = 1'b0; mid();
    chk("busy_reissue_busy", 32'(sub_busy), 32'h2);
    chk("busy_reissue_raddr", 32'(vreg_raddr), 42);
    tick(); mid();
    tick(); mid();
    chk("busy_reissue_exec", 32'(exec), 32'h2);
    tick(); exec_done = 4'b0010; mid();
    tick(); exec_done = '0; mid();
    wait_ret("busy_cnt", b + 2);
    chk_ret("busy_r0", b,     2'd1, 6'd41, ~vpat(40));
    chk_ret("busy_r1", b + 1, 2'd1, 6'd43, ~vpat(42));

    // Done pulse on an idle sub-unit.
    tick(); mid();
    chk("spur_pre_err", 32'(err_spur), 0);
    chk("spur_pre_idle", 32'(idle), 1);
    b = rq.size();
    tick(); exec_done = 4'b0100; mid();
    tick(); exec_done = '0; mid();
    chk("spur_err", 32'(err_spur), 1);
    chk("spur_output_re", 32'(output_re), 0);
    tick(); mid();
    tick(); mid();
    chk("spur_err_sticky", 32'(err_spur), 1);
    chk("spur_vreg_we", 32'(vreg_we), 0);
    chk("spur_output_re2", 32'(output_re), 0);
    chk("spur_no_retire", 32'(rq.size()), 32'(b));

    // Reset while the second command sits in ISS_LOAD and sub0 is still computing.
    issue(2'd0, 6'd50, 6'd52);
    send(2'd1, 6'd51, 6'd53);
    tick(); cif.cmd_valid = 1'b0; mid();
    chk("mid_rst_c1", 32'(vreg_re), 1);
    tick(); rst = 1'b1; mid();
    chk("mid_rst_input_we", 32'(input_we), 0);
    chk("mid_rst_vreg_re", 32'(vreg_re), 0);
    chk("mid_rst_exec", 32'(exec), 0);
    chk("mid_rst_output_re", 32'(output_re), 0);
    chk("mid_rst_vreg_we", 32'(vreg_we), 0);
    chk("mid_rst_busy", 32'(sub_busy), 0);
    chk("mid_rst_err", 32'(err_spur), 0);
    chk("mid_rst_idle", 32'(idle), 1);
    chk("mid_rst_ready", 32'(cif.cmd_ready), 1);
    tick(); rst = 1'b0; mid();
    chk("post_rst_idle", 32'(idle), 1);
    b = rq.size();
    tick(); exec_done = 4'b0001; mid();
    tick(); exec_done = '0; mid();
    chk("late_done_err", 32'(err_spur), 1);
    chk("late_done_output_re", 32'(output_re), 0);
    tick(); mid();
    chk("late_done_vreg_we", 32'(vreg_we), 0);
    chk("late_done_no_retire", 32'(rq.size()), 32'(b));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
